// File: rtl/pie_pkg.sv
// rtl/pie_pkg.sv - shared state type, counter sizing and default timing for the PIE carrier controller
package pie_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELIM = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TAIL  = 3'd4
    } pie_state_t;

    localparam int DEF_STEP_DIV     = 1;
    localparam int DEF_TARI_CYCLES  = 16;
    localparam int DEF_PW_CYCLES    = 8;
    localparam int DEF_DELIM_CYCLES = 12;
    localparam int DEF_TAIL_CYCLES  = 16;
    localparam int DEF_DEPTH_SHIFT  = 3;

    // Wide enough for the longest single-state dwell with margin.
    function automatic int cnt_width(input int tari, input int delim, input int tail);
        return $clog2(2 * tari + delim + tail + 1);
    endfunction

endpackage

// File: rtl/step_strobe_gen.sv
// rtl/step_strobe_gen.sv - free-running divider producing the sine generator step strobe
module step_strobe_gen #(
    parameter int STEP_DIV = 1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic enable_in,
    output logic step_out
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] WRAP = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          hit;

    assign hit = (cnt_q == WRAP);

    // Count 0..STEP_DIV-1 while enabled; disable restarts the count from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable_in) begin
            cnt_d = '0;
        end else if (hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_out = enable_in && !rst_in && hit;

endmodule

// File: rtl/pie_carrier_ctrl.sv
// rtl/pie_carrier_ctrl.sv - PIE encoder/ASK modulator for the carrier; PIE_DELIMITER_EN adds the frame-start delimiter
module pie_carrier_ctrl
    import pie_pkg::*;
#(
    parameter int STEP_DIV     = DEF_STEP_DIV,
    parameter int TARI_CYCLES  = DEF_TARI_CYCLES,
    parameter int PW_CYCLES    = DEF_PW_CYCLES,
    parameter int DELIM_CYCLES = DEF_DELIM_CYCLES,
    parameter int TAIL_CYCLES  = DEF_TAIL_CYCLES,
    parameter int DEPTH_SHIFT  = DEF_DEPTH_SHIFT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               bit_in,
    input  logic               bit_last_in,
    input  logic               bit_valid_in,
    output logic               bit_ready_out,
    output logic               step_out,
    input  logic signed [15:0] amp_in,
    output logic signed [15:0] amp_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               underrun_out
);

    if (PW_CYCLES < 1 || PW_CYCLES >= TARI_CYCLES) begin : g_bad_pw
        $error("pie_carrier_ctrl: PW_CYCLES must satisfy 1 <= PW_CYCLES < TARI_CYCLES");
    end
    if (DEPTH_SHIFT < 1 || DEPTH_SHIFT > 15) begin : g_bad_shift
        $error("pie_carrier_ctrl: DEPTH_SHIFT must be in 1..15");
    end

    localparam int CW = cnt_width(TARI_CYCLES, DELIM_CYCLES, TAIL_CYCLES);
    // Counter load values are dwell length minus one; a state ends when the counter reads zero.
    localparam logic [CW-1:0] LD_HIGH0 = CW'(TARI_CYCLES - PW_CYCLES - 1);
    localparam logic [CW-1:0] LD_HIGH1 = CW'(2 * TARI_CYCLES - PW_CYCLES - 1);
    localparam logic [CW-1:0] LD_LOW   = CW'(PW_CYCLES - 1);
    localparam logic [CW-1:0] LD_TAIL  = CW'(TAIL_CYCLES - 1);
`ifdef PIE_DELIMITER_EN
    localparam logic [CW-1:0] LD_DELIM = CW'(DELIM_CYCLES - 1);
`endif

    pie_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               bit_q, bit_d;
    logic               last_q, last_d;
    logic signed [15:0] amp_q, amp_d;

    logic ready;
    logic done;
    logic underrun;
    logic dwell_end;
    logic modulated;

    assign dwell_end = (cnt_q == '0);

    step_strobe_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_step (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .enable_in (enable_in),
        .step_out  (step_out)
    );

    // Next-state, dwell counter and handshake decode for the PIE symbol sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = dwell_end ? '0 : cnt_q - CW'(1);
        bit_d    = bit_q;
        last_d   = last_q;
        ready    = 1'b0;
        done     = 1'b0;
        underrun = 1'b0;
        if (!enable_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready = 1'b1;
                    if (bit_valid_in) begin
                        bit_d  = bit_in;
                        last_d = bit_last_in;
`ifdef PIE_DELIMITER_EN
                        state_d = DELIM;
                        cnt_d   = LD_DELIM;
`else
                        state_d = HIGH;
                        cnt_d   = bit_in ? LD_HIGH1 : LD_HIGH0;
`endif
                    end
                end
`ifdef PIE_DELIMITER_EN
                DELIM: begin
                    if (dwell_end) begin
                        state_d = HIGH;
                        cnt_d   = bit_q ? LD_HIGH1 : LD_HIGH0;
                    end
                end
`endif
                HIGH: begin
                    if (dwell_end) begin
                        state_d = LOW;
                        cnt_d   = LD_LOW;
                    end
                end
                LOW: begin
                    if (dwell_end) begin
                        if (last_q) begin
                            state_d = TAIL;
                            cnt_d   = LD_TAIL;
                        end else begin
                            ready = 1'b1;
                            if (bit_valid_in) begin
                                bit_d   = bit_in;
                                last_d  = bit_last_in;
                                state_d = HIGH;
                                cnt_d   = bit_in ? LD_HIGH1 : LD_HIGH0;
                            end else begin
                                underrun = 1'b1;
                                state_d  = TAIL;
                                cnt_d    = LD_TAIL;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (dwell_end) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Amplitude select: carrier is pulled down to the modulated level in DELIM and LOW.
    always_comb begin
        modulated = (state_q == DELIM) || (state_q == LOW);
        amp_d     = amp_in;
        if (!enable_in) begin
            amp_d = '0;
        end else if (modulated) begin
            amp_d = amp_in >>> DEPTH_SHIFT;
        end
    end

    // State, dwell counter, current bit and output amplitude registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
            amp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            amp_q   <= amp_d;
        end
    end

    assign bit_ready_out = ready && !rst_in;
    assign done_out      = done && !rst_in;
    assign underrun_out  = underrun && !rst_in;
    assign busy_out      = (state_q != IDLE) && !rst_in;
    assign amp_out       = amp_q;

endmodule

// File: tb/tb_pie_carrier_ctrl.sv
// tb/tb_pie_carrier_ctrl.sv - randomized bench for pie_carrier_ctrl against a symbol-timeline model
module tb_pie_carrier_ctrl;

    localparam int TARI  = 8;
    localparam int PW    = 4;
    localparam int DLM   = 6;
    localparam int TAILC = 5;
    localparam int SHIFT = 3;
`ifdef PIE_DELIMITER_EN
    localparam int DLM_ON = 1;
`else
    localparam int DLM_ON = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               b_bit;
    logic               b_last;
    logic               b_valid;
    logic signed [15:0] amp;

    logic               a_rdy, a_step, a_busy, a_done, a_und;
    logic signed [15:0] a_amp;
    logic               c_rdy, c_step, c_busy, c_done, c_und;
    logic signed [15:0] c_amp;

    always #5 clk = ~clk;

    pie_carrier_ctrl #(
        .STEP_DIV(1), .TARI_CYCLES(TARI), .PW_CYCLES(PW),
        .DELIM_CYCLES(DLM), .TAIL_CYCLES(TAILC), .DEPTH_SHIFT(SHIFT)
    ) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(en),
        .bit_in(b_bit), .bit_last_in(b_last), .bit_valid_in(b_valid),
        .bit_ready_out(a_rdy), .step_out(a_step), .amp_in(amp), .amp_out(a_amp),
        .busy_out(a_busy), .done_out(a_done), .underrun_out(a_und)
    );

    pie_carrier_ctrl #(
        .STEP_DIV(4), .TARI_CYCLES(TARI), .PW_CYCLES(PW),
        .DELIM_CYCLES(DLM), .TAIL_CYCLES(TAILC), .DEPTH_SHIFT(SHIFT)
    ) dut4 (
        .clk_in(clk), .rst_in(rst), .enable_in(en),
        .bit_in(b_bit), .bit_last_in(b_last), .bit_valid_in(b_valid),
        .bit_ready_out(c_rdy), .step_out(c_step), .amp_in(amp), .amp_out(c_amp),
        .busy_out(c_busy), .done_out(c_done), .underrun_out(c_und)
    );

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;

    // Model: 0 idle, 1 in frame (delimiter or symbols), 2 tail.
    int m_mode = 0;
    int m_sym  = 0;
    int m_tail = 0;
    int m_bit  = 0;
    int m_last = 0;
    int m_amp  = 0;
    int m_en_run = 0;

    logic [1:0] feed[$];
    logic       hold = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if (a < 0 && (a % d) != 0) q = q - 1;
        return q;
    endfunction

    task automatic drive_bits();
        b_valid = (feed.size() > 0) && !hold;
        if (feed.size() > 0) begin
            b_bit  = feed[0][0];
            b_last = feed[0][1];
        end else begin
            b_bit  = 1'($urandom_range(0, 1));
            b_last = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        int e_rdy, e_busy, e_done, e_und, e_mod, e_s1, e_s4, nxt_amp, o, hl;
        bit xfer;
        @(negedge clk);
        e_rdy = 0; e_busy = 0; e_done = 0; e_und = 0; e_mod = 0;
        xfer = 1'b0;
        e_s1 = (!rst && en) ? 1 : 0;
        e_s4 = (!rst && en && (m_en_run % 4) == 3) ? 1 : 0;
        nxt_amp = 0;
        if (rst) begin
            m_mode = 0;
        end else if (!en) begin
            e_busy = (m_mode != 0);
            m_mode = 0;
        end else begin
            e_busy = (m_mode != 0);
            case (m_mode)
                0: begin
                    e_rdy = 1;
                    if (b_valid) begin
                        xfer   = 1'b1;
                        m_bit  = b_bit;
                        m_last = b_last;
                        m_sym  = t + 1 + DLM_ON * DLM;
                        m_mode = 1;
                    end
                end
                1: begin
                    o = t - m_sym;
                    if (o < 0) begin
                        e_mod = 1;
                    end else begin
                        hl = (m_bit != 0) ? 2 * TARI - PW : TARI - PW;
                        e_mod = (o >= hl);
                        if (o == hl + PW - 1) begin
                            if (m_last != 0) begin
                                m_mode = 2; m_tail = t + 1;
                            end else begin
                                e_rdy = 1;
                                if (b_valid) begin
                                    xfer   = 1'b1;
                                    m_bit  = b_bit;
                                    m_last = b_last;
                                    m_sym  = t + 1;
                                end else begin
                                    e_und  = 1;
                                    m_mode = 2; m_tail = t + 1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    if (t - m_tail == TAILC - 1) begin
                        e_done = 1;
                        m_mode = 0;
                    end
                end
            endcase
            nxt_amp = (e_mod != 0) ? floor_div(int'(amp), 1 << SHIFT) : int'(amp);
        end
        check_val("ready",    a_rdy,  e_rdy);
        check_val("step",     a_step, e_s1);
        check_val("busy",     a_busy, e_busy);
        check_val("done",     a_done, e_done);
        check_val("underrun", a_und,  e_und);
        check_val("amp",      int'(a_amp), m_amp);
        check_val("div4_step", c_step, e_s4);
        check_val("div4_ready", c_rdy, e_rdy);
        check_val("div4_busy", c_busy, e_busy);
        check_val("div4_done", c_done, e_done);
        check_val("div4_underrun", c_und, e_und);
        check_val("div4_amp", int'(c_amp), m_amp);
        m_amp    = nxt_amp;
        m_en_run = (rst || !en) ? 0 : m_en_run + 1;
        if (xfer && feed.size() > 0) void'(feed.pop_front());
        t++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; amp = 16'sd8000;
        drive_bits();
        repeat (3) tick();

        // Idle carrier with no bits.
        rst = 1'b0; en = 1'b1;
        repeat (6) begin drive_bits(); tick(); end

        // Frame {0, 1 last}.
        feed.push_back(2'b00); feed.push_back(2'b11);
        repeat (45) begin drive_bits(); tick(); end

        // Underrun: one non-last bit with nothing behind it, negative carrier.
        amp = -16'sd8000;
        feed.push_back(2'b01);
        repeat (40) begin drive_bits(); tick(); end
        amp = 16'sd8000;

        // Reset in the 3rd HIGH cycle.
        feed.push_back(2'b00); feed.push_back(2'b11);
        drive_bits(); tick();
        repeat (DLM_ON * DLM + 2) begin drive_bits(); tick(); end
        rst = 1'b1; feed.delete(); drive_bits(); tick();
        rst = 1'b0;
        repeat (12) begin drive_bits(); tick(); end

        // Enable low for two cycles, then restart.
        en = 1'b0; repeat (2) begin drive_bits(); tick(); end
        en = 1'b1; repeat (10) begin drive_bits(); tick(); end

        // Randomized frames, drops, disables, resets and amplitudes.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: amp = 16'sd8000;
                1: amp = -16'sd8000;
                default: amp = 16'($urandom);
            endcase
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 79) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 1) == 0) en = 1'b1;
            if (feed.size() == 0 && $urandom_range(0, 15) == 0) begin
                int nb;
                nb = $urandom_range(1, 5);
                for (int k = 0; k < nb; k++)
                    feed.push_back({(k == nb - 1) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1))});
            end
            hold = ($urandom_range(0, 11) == 0);
            drive_bits();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
